// File: rtl/audio_tdm_deserializer_if.sv
// Consumer side of the TDM deserializer: first-word-fall-through head frame plus fill status.
interface audio_tdm_deserializer_if #(
  parameter int unsigned FRAME_WIDTH = 48,
  parameter int unsigned LEVEL_WIDTH = 5
);
  logic                   read;
  logic [FRAME_WIDTH-1:0] frame_data;
  logic                   available;
  logic                   level_ok;
  logic [LEVEL_WIDTH-1:0] fill_level;

  modport master (input read, output frame_data, available, level_ok, fill_level);
  modport slave (output read, input frame_data, available, level_ok, fill_level);
endinterface

// File: rtl/audio_tdm_deserializer.sv
// Codec ADC input: deserialises left-justified / I2S / TDM frames and queues whole
// frames in a first-word-fall-through FIFO for the sample consumer.
module audio_tdm_deserializer #(
  parameter int unsigned SAMPLE_WIDTH   = 24,
  parameter int unsigned SLOT_WIDTH     = 32,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned MODE           = 0,
  parameter int unsigned READ_THRESHOLD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic aud_bclk,
  input  logic aud_lrclk,
  input  logic aud_adcdat,
  audio_tdm_deserializer_if.master frame_if,
  output logic synced,
  output logic overflow,
  output logic frame_error
);

  localparam int unsigned FrameW = CHANNELS * SAMPLE_WIDTH;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = PtrW + 1;
  localparam int unsigned BitW   = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int unsigned ChW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {StWaitSync, StCapture, StPush, StIdleTail} state_e;

  // Synchronisers are deliberately not reset so a reset/clear cannot fake an lrclk edge.
  logic [2:0] bclk_sync_q, lrclk_sync_q, dat_sync_q;
  logic       bclk_rise, lrclk_rise, dat_bit;

  always_ff @(posedge clk) begin
    bclk_sync_q  <= {bclk_sync_q[1:0], aud_bclk};
    lrclk_sync_q <= {lrclk_sync_q[1:0], aud_lrclk};
    dat_sync_q   <= {dat_sync_q[1:0], aud_adcdat};
  end

  assign bclk_rise  = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lrclk_rise = lrclk_sync_q[1] & ~lrclk_sync_q[2];
  assign dat_bit    = dat_sync_q[1];

  state_e             state_q, state_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ChW-1:0]     ch_idx_q, ch_idx_d;
  logic [FrameW-1:0]  frame_sr_q, frame_sr_d;
  logic               synced_q, synced_d, frame_error_q, frame_error_d;
  logic [31:0]        bit_pos;
  logic               in_window, bit_last, ch_last;

  assign bit_pos   = 32'(bit_cnt_q);
  assign in_window = (bit_pos >= MODE) && (bit_pos < MODE + SAMPLE_WIDTH);
  assign bit_last  = (bit_pos == SLOT_WIDTH - 1);
  assign ch_last   = (32'(ch_idx_q) == CHANNELS - 1);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    ch_idx_d      = ch_idx_q;
    frame_sr_d    = frame_sr_q;
    synced_d      = synced_q;
    frame_error_d = frame_error_q;
    unique case (state_q)
      StWaitSync: begin
        if (lrclk_rise) begin
          state_d   = StCapture;
          bit_cnt_d = '0;
          ch_idx_d  = '0;
          synced_d  = 1'b1;
        end
      end
      StCapture: begin
        if (lrclk_rise) begin
          // Early frame boundary: drop the partial frame and restart at ch0.
          frame_error_d = 1'b1;
          bit_cnt_d     = '0;
          ch_idx_d      = '0;
        end else if (bclk_rise) begin
          if (in_window) frame_sr_d = {frame_sr_q[FrameW-2:0], dat_bit};
          if (bit_last) begin
            bit_cnt_d = '0;
            if (ch_last) state_d = StPush;
            else         ch_idx_d = ch_idx_q + ChW'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StPush: begin
        state_d   = lrclk_rise ? StCapture : StIdleTail;
        bit_cnt_d = '0;
        ch_idx_d  = '0;
      end
      StIdleTail: begin
        if (lrclk_rise) begin
          state_d   = StCapture;
          bit_cnt_d = '0;
          ch_idx_d  = '0;
        end
      end
      default: state_d = StWaitSync;
    endcase
  end

  // Frame FIFO with a registered head so frame_data is valid whenever available is set.
  logic [FrameW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] count_q, count_d;
  logic [FrameW-1:0] head_q, head_d;
  logic              available_q, level_ok_q, overflow_q, overflow_d;
  logic              push, pop, full, push_ok;

  assign push    = (state_q == StPush);
  assign full    = (count_q == LevelW'(FIFO_DEPTH));
  assign pop     = frame_if.read & (count_q != '0);
  assign push_ok = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + LevelW'(1);
      2'b01:   count_d = count_q - LevelW'(1);
      default: count_d = count_q;
    endcase
    head_d = '0;
    if (count_d != '0) begin
      // The new head may be the frame being written this very cycle.
      head_d = (push_ok && rd_ptr_d == wr_ptr_q) ? frame_sr_q : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= frame_sr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_q       <= StWaitSync;
      bit_cnt_q     <= '0;
      ch_idx_q      <= '0;
      frame_sr_q    <= '0;
      synced_q      <= 1'b0;
      frame_error_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_q        <= '0;
      available_q   <= 1'b0;
      level_ok_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      ch_idx_q      <= ch_idx_d;
      frame_sr_q    <= frame_sr_d;
      synced_q      <= synced_d;
      frame_error_q <= frame_error_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_q        <= head_d;
      available_q   <= (count_d != '0);
      level_ok_q    <= (32'(count_d) >= READ_THRESHOLD);
      overflow_q    <= overflow_d;
    end
  end

  assign frame_if.frame_data = head_q;
  assign frame_if.available  = available_q;
  assign frame_if.level_ok   = level_ok_q;
  assign frame_if.fill_level = count_q;
  assign synced              = synced_q;
  assign overflow            = overflow_q;
  assign frame_error         = frame_error_q;

endmodule

// File: tb/tb_audio_tdm_deserializer.sv
// Directed bench: stereo LJ / depth-4 instance plus a 4-channel I2S instance on shared codec pins.
module tb_audio_tdm_deserializer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic aud_bclk = 1'b1;
  logic aud_lrclk = 1'b0;
  logic aud_adcdat = 1'b0;
  logic synced0, overflow0, frame_error0;
  logic synced1, overflow1, frame_error1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  audio_tdm_deserializer_if #(.FRAME_WIDTH(48), .LEVEL_WIDTH(3)) bus0 ();
  audio_tdm_deserializer_if #(.FRAME_WIDTH(96), .LEVEL_WIDTH(5)) bus1 ();

  audio_tdm_deserializer #(
    .SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(2), .FIFO_DEPTH(4), .MODE(0),
    .READ_THRESHOLD(4)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .aud_bclk(aud_bclk),
    .aud_lrclk(aud_lrclk), .aud_adcdat(aud_adcdat), .frame_if(bus0),
    .synced(synced0), .overflow(overflow0), .frame_error(frame_error0)
  );

  audio_tdm_deserializer #(
    .SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(4), .FIFO_DEPTH(16), .MODE(1),
    .READ_THRESHOLD(4)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .aud_bclk(aud_bclk),
    .aud_lrclk(aud_lrclk), .aud_adcdat(aud_adcdat), .frame_if(bus1),
    .synced(synced1), .overflow(overflow1), .frame_error(frame_error1)
  );

  initial begin
    bus0.read = 1'b0;
    bus1.read = 1'b0;
  end

  function automatic logic [47:0] fr(input int k);
    logic [23:0] l;
    l = 24'(k * 24'h111111);
    return {l, ~l};
  endfunction

  // One frame of nch slots; pad bits outside the sample window are driven 1.
  task automatic send_frame(input int nch, input int mode, input logic [95:0] s,
                            input bit read_on_push);
    logic [23:0] smp;
    logic        b;
    @(negedge clk);
    for (int ch = 0; ch < nch; ch++) begin
      smp = s[95-24*ch -: 24];
      for (int k = 0; k < 32; k++) begin
        b = (k >= mode && k < mode + 24) ? smp[23-(k-mode)] : 1'b1;
        aud_lrclk = (ch == 0);
        aud_bclk = 1'b0;
        aud_adcdat = b;
        #40;
        aud_bclk = 1'b1;
        if (read_on_push && ch == nch - 1 && k == 31) begin
          // Last bclk rise -> edge pulse seen on the 3rd clk edge -> PUSH on the 4th.
          repeat (3) @(posedge clk);
          #1 bus0.read = 1'b1;
          @(posedge clk);
          #1 bus0.read = 1'b0;
        end else begin
          #40;
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input int n, input logic lr, input logic b);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      aud_lrclk = lr;
      aud_bclk = 1'b0;
      aud_adcdat = b;
      #40;
      aud_bclk = 1'b1;
      #40;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic pop0();
    @(negedge clk) bus0.read = 1'b1;
    @(negedge clk) bus0.read = 1'b0;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus0.available !== 1'b0) begin n_fail++; $display("FAIL reset_available got %b want 0", bus0.available); end
    n_cmp++; if (bus0.fill_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus0.fill_level); end
    n_cmp++; if (bus0.frame_data !== 48'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus0.frame_data); end
    n_cmp++; if ({synced0, overflow0, frame_error0, bus0.level_ok} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {synced0, overflow0, frame_error0, bus0.level_ok}); end
  endtask

  task automatic test_stereo_lj();
    do_clear();
    send_frame(2, 0, {24'hA5A5A5, 24'h5A5A5A, 48'h0}, 1'b0);
    n_cmp++; if (bus0.frame_data !== 48'hA5A5A55A5A5A) begin n_fail++; $display("FAIL lj_data got %h want a5a5a55a5a5a", bus0.frame_data); end
    n_cmp++; if (bus0.available !== 1'b1) begin n_fail++; $display("FAIL lj_available got %b want 1", bus0.available); end
    n_cmp++; if (bus0.fill_level !== 3'd1) begin n_fail++; $display("FAIL lj_level got %0d want 1", bus0.fill_level); end
    n_cmp++; if (synced0 !== 1'b1) begin n_fail++; $display("FAIL lj_synced got %b want 1", synced0); end
    pop0();
    n_cmp++; if ({bus0.available, bus0.fill_level} !== 4'b0) begin n_fail++; $display("FAIL lj_pop got %b want 0000", {bus0.available, bus0.fill_level}); end
  endtask

  task automatic test_i2s_tdm();
    do_clear();
    send_frame(4, 1, {24'h000001, 24'h800000, 24'h7FFFFF, 24'h123456}, 1'b0);
    n_cmp++; if (bus1.frame_data !== 96'h000001_800000_7FFFFF_123456) begin n_fail++; $display("FAIL i2s_data got %h want 0000018000007fffff123456", bus1.frame_data); end
    n_cmp++; if ({bus1.available, bus1.fill_level} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL i2s_level got %b/%0d want 1/1", bus1.available, bus1.fill_level); end
    n_cmp++; if (frame_error1 !== 1'b0) begin n_fail++; $display("FAIL i2s_error got %b want 0", frame_error1); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int k = 1; k <= 6; k++) begin
      send_frame(2, 0, {fr(k), 48'h0}, 1'b0);
      if (k == 3) begin
        n_cmp++; if ({bus0.fill_level, bus0.level_ok} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL ovf_level3 got %0d/%b want 3/0", bus0.fill_level, bus0.level_ok); end
      end
      if (k == 4) begin
        n_cmp++; if ({bus0.fill_level, bus0.level_ok, overflow0} !== {3'd4, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ovf_level4 got %0d/%b/%b want 4/1/0", bus0.fill_level, bus0.level_ok, overflow0); end
      end
    end
    n_cmp++; if ({bus0.fill_level, overflow0} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL ovf_full got %0d/%b want 4/1", bus0.fill_level, overflow0); end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (bus0.frame_data !== fr(k)) begin n_fail++; $display("FAIL ovf_read%0d got %h want %h", k, bus0.frame_data, fr(k)); end
      pop0();
      if (k == 1) begin
        n_cmp++; if ({bus0.fill_level, bus0.level_ok} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL ovf_after_pop got %0d/%b want 3/0", bus0.fill_level, bus0.level_ok); end
      end
    end
    n_cmp++; if ({bus0.available, bus0.fill_level} !== 4'b0) begin n_fail++; $display("FAIL ovf_drained got %b want 0000", {bus0.available, bus0.fill_level}); end
    pop0();
    n_cmp++; if ({bus0.available, bus0.fill_level} !== 4'b0) begin n_fail++; $display("FAIL ovf_read_empty got %b want 0000", {bus0.available, bus0.fill_level}); end
  endtask

  task automatic test_frame_error();
    do_clear();
    send_bits(32, 1'b1, 1'b1);
    send_bits(8, 1'b0, 1'b0);
    n_cmp++; if ({bus0.fill_level, frame_error0} !== 4'b0) begin n_fail++; $display("FAIL ferr_partial got %0d/%b want 0/0", bus0.fill_level, frame_error0); end
    send_frame(2, 0, {fr(9), 48'h0}, 1'b0);
    n_cmp++; if (frame_error0 !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got %b want 1", frame_error0); end
    n_cmp++; if ({bus0.fill_level, bus0.frame_data} !== {3'd1, fr(9)}) begin n_fail++; $display("FAIL ferr_next got %0d/%h want 1/%h", bus0.fill_level, bus0.frame_data, fr(9)); end
  endtask

  task automatic test_resync_clear();
    do_clear();
    send_bits(40, 1'b0, 1'b1);
    n_cmp++; if ({synced0, bus0.available} !== 2'b00) begin n_fail++; $display("FAIL sync_before got %b want 00", {synced0, bus0.available}); end
    send_frame(2, 0, {fr(7), 48'h0}, 1'b0);
    n_cmp++; if ({synced0, bus0.fill_level, bus0.frame_data} !== {1'b1, 3'd1, fr(7)}) begin n_fail++; $display("FAIL sync_first got %b/%0d/%h want 1/1/%h", synced0, bus0.fill_level, bus0.frame_data, fr(7)); end
    send_bits(20, 1'b1, 1'b1);
    do_clear();
    n_cmp++; if ({synced0, bus0.available, bus0.fill_level, bus0.level_ok, overflow0, frame_error0} !== 8'b0) begin n_fail++; $display("FAIL clear_flags got %b want 00000000", {synced0, bus0.available, bus0.fill_level, bus0.level_ok, overflow0, frame_error0}); end
    send_bits(12, 1'b1, 1'b0);
    send_bits(32, 1'b0, 1'b1);
    n_cmp++; if ({synced0, bus0.available} !== 2'b00) begin n_fail++; $display("FAIL clear_nosync got %b want 00", {synced0, bus0.available}); end
    send_frame(2, 0, {fr(8), 48'h0}, 1'b0);
    n_cmp++; if ({synced0, bus0.fill_level, bus0.frame_data} !== {1'b1, 3'd1, fr(8)}) begin n_fail++; $display("FAIL clear_resync got %b/%0d/%h want 1/1/%h", synced0, bus0.fill_level, bus0.frame_data, fr(8)); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int k = 1; k <= 4; k++) send_frame(2, 0, {fr(k), 48'h0}, 1'b0);
    send_frame(2, 0, {fr(5), 48'h0}, 1'b1);
    n_cmp++; if ({bus0.fill_level, overflow0} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL b2b_level got %0d/%b want 4/0", bus0.fill_level, overflow0); end
    for (int k = 2; k <= 5; k++) begin
      n_cmp++; if (bus0.frame_data !== fr(k)) begin n_fail++; $display("FAIL b2b_read%0d got %h want %h", k, bus0.frame_data, fr(k)); end
      pop0();
    end
  endtask

  initial begin
    test_reset();
    test_stereo_lj();
    test_i2s_tdm();
    test_overflow();
    test_frame_error();
    test_resync_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
